stage_ex: RTL and testbench
===========================

// Module: stage_ex
// PURPOSE
//  Execute stage of the 8-bit in-order pipeline, directly upstream of the memory stage.
//  - Resolves operand forwarding and computes the ALU result.
//  - Registers data and control into the EX/MEM pipeline register that feeds the memory stage.
//  - Honors stall/flush from the hazard unit; optionally runs a multi-cycle multiply.
// PARAMETERS
//  DATA_W   8   datapath width (operands, immediate, result)
//  REG_AW   3   register-address width (rd)
// PORTS
//  clk             in   1       rising-edge clock; single clock domain
//  reset           in   1       synchronous, active-high
//  stall_in        in   1       hold EX/MEM register (hazard unit)
//  flush_in        in   1       load a bubble into EX/MEM
//  RegWrite_EX     in   1       control: register write
//  MemRead_EX      in   1       control: load
//  MemWrite_EX     in   1       control: store
//  ResultSrc_EX    in   1       control: 1 = WB takes mem data
//  alu_op_EX       in   4       ALU operation (pipeline_pkg encodings)
//  alu_src_EX      in   1       1 = operand B from imm_EX
//  rs1_data_EX     in   DATA_W  register-file operand A
//  rs2_data_EX     in   DATA_W  register-file operand B / store data
//  imm_EX          in   DATA_W  immediate
//  rd_EX           in   REG_AW  destination register
//  forward_A       in   2       00 = reg, 01 = WB value, 10 = MEM value, 11 = reg
//  forward_B       in   2       same encoding, applied before the alu_src mux
//  fwd_mem_data    in   DATA_W  EX/MEM alu_result (MEM-stage forward)
//  fwd_wb_data     in   DATA_W  write-back value
//  MemRead_MEM     out  1       registered control to MEM
//  MemWrite_MEM    out  1       registered control to MEM
//  ResultSrc_MEM   out  1       registered control to MEM
//  RegWrite_MEM    out  1       registered control to MEM
//  rd_MEM          out  REG_AW  registered destination
//  alu_result_MEM  out  DATA_W  registered ALU result (memory address for ld/st)
//  write_data_MEM  out  DATA_W  registered forwarded operand B (pre-imm mux)
//  zero_MEM        out  1       registered (alu_result == 0)
//  ex_busy         out  1       multi-cycle op in progress; hazard unit must stall upstream
// BEHAVIOUR
//  - Reset (sync): all registered outputs 0; FSM to IDLE; ex_busy = 0.
//  - Latency: 1 cycle, inputs -> EX/MEM outputs, for all single-cycle ops.
//  - Arithmetic: all results mod 2^DATA_W.
//    - ADD, SUB, AND, OR, XOR: as named.
//    - SLL / SRL: shift amount = B[2:0].
//    - SLT: signed compare; result 8'h01 or 8'h00.
//    - PASSB: result = B.
//    - Undefined codes: result 0.
//  - Per cycle, priority flush > stall > load:
//    - flush_in: EX/MEM loads a bubble (all controls 0, data 0, rd 0).
//    - stall_in: EX/MEM holds its contents.
//    - Otherwise: EX/MEM loads the computed values.
//  - Bubble guarantees no register write and no memory access downstream.
//  - The multiply FSM is IDLE / MUL / DONE (present only with MUL_EN; see CONFIGURATION).
// CONFIGURATION
//  STAGE_EX_MUL_EN defined:
//    - alu_op MUL starts a shift-add multiply (low DATA_W bits of the product).
//    - IDLE -> MUL on a MUL op when not stalled: operands captured; ex_busy = 1 from the next cycle.
//    - MUL lasts DATA_W cycles; EX/MEM loads a bubble each of these cycles.
//    - DONE (1 cycle): EX/MEM loads the product with the captured rd/controls; ex_busy = 0; -> IDLE.
//    - Operand changes during MUL are ignored.
//    - flush_in in MUL or DONE aborts to IDLE; bubble loaded; ex_busy = 0 next cycle.
//    - reset mid-operation: IDLE, no result.
//  STAGE_EX_MUL_EN undefined: MUL yields 0 in one cycle; ex_busy tied 0; no FSM logic.
// STRUCTURE
//  - pipeline_pkg: alu_op encodings, FWD_REG/FWD_WB/FWD_MEM constants, mul-FSM state enum.
//  - One sub-module, alu_core: combinational ALU (op, a, b -> result).
//  - Forwarding muxes, EX/MEM register and mul FSM live in stage_ex.
// TESTING
//  1. ADD, rs1 = 8'h7F, imm = 8'h01, alu_src = 1 -> next cycle alu_result_MEM = 8'h80, zero_MEM = 0.
//  2. SUB 5 - 5, forward_A = 10 with fwd_mem_data = 5 -> alu_result_MEM = 0, zero_MEM = 1.
//  3. SLT, a = 8'hFF, b = 8'h01 -> 8'h01. SLL, 8'h81 by 3 -> 8'h08.
//  4. Store, forward_B = 01, fwd_wb_data = 8'hA5, alu_src = 1 -> write_data_MEM = 8'hA5, MemWrite_MEM = 1.
//  5. stall_in and flush_in both high for 1 cycle -> bubble loaded (RegWrite_MEM = MemWrite_MEM = 0);
//     stall_in alone -> outputs held.
//  6. (MUL_EN) MUL 8'h0C x 8'h0B:
//     - ex_busy high for 8 cycles, then alu_result_MEM = 8'h84.
//     - Repeat with flush_in on cycle 4 -> no result, ex_busy drops.

Source files
------------

// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module : pipeline_pkg
// Brief  : Shared encodings for the 8-bit pipeline: ALU ops, forward selects,
//          multiply-FSM states.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package pipeline_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SLT   = 4'd7,
        ALU_PASSB = 4'd8,
        ALU_MUL   = 4'd9
    } alu_op_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// ============================================================================
// Module : alu_core
// Brief  : Combinational ALU; MUL and unknown codes produce 0 here.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_core
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [3:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:   o_result = i_a + i_b;
            ALU_SUB:   o_result = i_a - i_b;
            ALU_AND:   o_result = i_a & i_b;
            ALU_OR:    o_result = i_a | i_b;
            ALU_XOR:   o_result = i_a ^ i_b;
            ALU_SLL:   o_result = i_a << i_b[2:0];
            ALU_SRL:   o_result = i_a >> i_b[2:0];
            ALU_SLT:   o_result = ($signed(i_a) < $signed(i_b)) ? DATA_W'(1) : '0;
            ALU_PASSB: o_result = i_b;
            default:   o_result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/stage_ex.sv
// ============================================================================
// Module : stage_ex
// Brief  : Execute stage: forwarding, ALU, EX/MEM register, optional
//          shift-add multiplier enabled by STAGE_EX_MUL_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module stage_ex
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              RegWrite_EX,
    input  logic              MemRead_EX,
    input  logic              MemWrite_EX,
    input  logic              ResultSrc_EX,
    input  logic [3:0]        alu_op_EX,
    input  logic              alu_src_EX,
    input  logic [DATA_W-1:0] rs1_data_EX,
    input  logic [DATA_W-1:0] rs2_data_EX,
    input  logic [DATA_W-1:0] imm_EX,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic [1:0]        forward_A,
    input  logic [1:0]        forward_B,
    input  logic [DATA_W-1:0] fwd_mem_data,
    input  logic [DATA_W-1:0] fwd_wb_data,
    output logic              MemRead_MEM,
    output logic              MemWrite_MEM,
    output logic              ResultSrc_MEM,
    output logic              RegWrite_MEM,
    output logic [REG_AW-1:0] rd_MEM,
    output logic [DATA_W-1:0] alu_result_MEM,
    output logic [DATA_W-1:0] write_data_MEM,
    output logic              zero_MEM,
    output logic              ex_busy
);

    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_fwd_b;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_alu_result;

    always_comb begin
        case (forward_A)
            FWD_WB:  w_op_a = fwd_wb_data;
            FWD_MEM: w_op_a = fwd_mem_data;
            default: w_op_a = rs1_data_EX;
        endcase
        case (forward_B)
            FWD_WB:  w_fwd_b = fwd_wb_data;
            FWD_MEM: w_fwd_b = fwd_mem_data;
            default: w_fwd_b = rs2_data_EX;
        endcase
        w_op_b = alu_src_EX ? imm_EX : w_fwd_b;
    end

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .i_op     (alu_op_EX),
        .i_a      (w_op_a),
        .i_b      (w_op_b),
        .o_result (w_alu_result)
    );

    logic              r_memread_q,  w_memread_d;
    logic              r_memwrite_q, w_memwrite_d;
    logic              r_resultsrc_q, w_resultsrc_d;
    logic              r_regwrite_q, w_regwrite_d;
    logic [REG_AW-1:0] r_rd_q,       w_rd_d;
    logic [DATA_W-1:0] r_result_q,   w_result_d;
    logic [DATA_W-1:0] r_wdata_q,    w_wdata_d;
    logic              r_zero_q,     w_zero_d;

`ifdef STAGE_EX_MUL_EN
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    mul_state_e        r_state_q, w_state_d;
    logic [CNT_W-1:0]  r_cnt_q,   w_cnt_d;
    logic [DATA_W-1:0] r_mcand_q, w_mcand_d;
    logic [DATA_W-1:0] r_mplier_q, w_mplier_d;
    logic [DATA_W-1:0] r_acc_q,   w_acc_d;
    logic              r_m_regwrite_q, w_m_regwrite_d;
    logic              r_m_memread_q,  w_m_memread_d;
    logic              r_m_memwrite_q, w_m_memwrite_d;
    logic              r_m_resultsrc_q, w_m_resultsrc_d;
    logic [REG_AW-1:0] r_m_rd_q,  w_m_rd_d;
    logic [DATA_W-1:0] r_m_wdata_q, w_m_wdata_d;
`endif

    always_comb begin
        w_memread_d   = r_memread_q;
        w_memwrite_d  = r_memwrite_q;
        w_resultsrc_d = r_resultsrc_q;
        w_regwrite_d  = r_regwrite_q;
        w_rd_d        = r_rd_q;
        w_result_d    = r_result_q;
        w_wdata_d     = r_wdata_q;
        w_zero_d      = r_zero_q;
`ifdef STAGE_EX_MUL_EN
        w_state_d       = r_state_q;
        w_cnt_d         = r_cnt_q;
        w_mcand_d       = r_mcand_q;
        w_mplier_d      = r_mplier_q;
        w_acc_d         = r_acc_q;
        w_m_regwrite_d  = r_m_regwrite_q;
        w_m_memread_d   = r_m_memread_q;
        w_m_memwrite_d  = r_m_memwrite_q;
        w_m_resultsrc_d = r_m_resultsrc_q;
        w_m_rd_d        = r_m_rd_q;
        w_m_wdata_d     = r_m_wdata_q;
`endif

        if (flush_in) begin
            w_memread_d   = 1'b0;
            w_memwrite_d  = 1'b0;
            w_resultsrc_d = 1'b0;
            w_regwrite_d  = 1'b0;
            w_rd_d        = '0;
            w_result_d    = '0;
            w_wdata_d     = '0;
            w_zero_d      = 1'b0;
`ifdef STAGE_EX_MUL_EN
            w_state_d     = MUL_IDLE;
`endif
        end else begin
`ifdef STAGE_EX_MUL_EN
            case (r_state_q)
                MUL_RUN: begin
                    // Multiplier owns the stage: bubbles go out regardless of stall.
                    w_memread_d   = 1'b0;
                    w_memwrite_d  = 1'b0;
                    w_resultsrc_d = 1'b0;
                    w_regwrite_d  = 1'b0;
                    w_rd_d        = '0;
                    w_result_d    = '0;
                    w_wdata_d     = '0;
                    w_zero_d      = 1'b0;
                    if (r_mplier_q[0]) begin
                        w_acc_d = r_acc_q + r_mcand_q;
                    end
                    w_mcand_d  = r_mcand_q << 1;
                    w_mplier_d = r_mplier_q >> 1;
                    w_cnt_d    = r_cnt_q + 1'b1;
                    if (r_cnt_q == CNT_W'(DATA_W - 1)) begin
                        w_state_d = MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    if (!stall_in) begin
                        w_memread_d   = r_m_memread_q;
                        w_memwrite_d  = r_m_memwrite_q;
                        w_resultsrc_d = r_m_resultsrc_q;
                        w_regwrite_d  = r_m_regwrite_q;
                        w_rd_d        = r_m_rd_q;
                        w_result_d    = r_acc_q;
                        w_wdata_d     = r_m_wdata_q;
                        w_zero_d      = (r_acc_q == '0);
                        w_state_d     = MUL_IDLE;
                    end
                end
                default: begin
                    if (!stall_in) begin
                        if (alu_op_EX == ALU_MUL) begin
                            w_memread_d     = 1'b0;
                            w_memwrite_d    = 1'b0;
                            w_resultsrc_d   = 1'b0;
                            w_regwrite_d    = 1'b0;
                            w_rd_d          = '0;
                            w_result_d      = '0;
                            w_wdata_d       = '0;
                            w_zero_d        = 1'b0;
                            w_mcand_d       = w_op_a;
                            w_mplier_d      = w_op_b;
                            w_acc_d         = '0;
                            w_cnt_d         = '0;
                            w_m_regwrite_d  = RegWrite_EX;
                            w_m_memread_d   = MemRead_EX;
                            w_m_memwrite_d  = MemWrite_EX;
                            w_m_resultsrc_d = ResultSrc_EX;
                            w_m_rd_d        = rd_EX;
                            w_m_wdata_d     = w_fwd_b;
                            w_state_d       = MUL_RUN;
                        end else begin
                            w_memread_d   = MemRead_EX;
                            w_memwrite_d  = MemWrite_EX;
                            w_resultsrc_d = ResultSrc_EX;
                            w_regwrite_d  = RegWrite_EX;
                            w_rd_d        = rd_EX;
                            w_result_d    = w_alu_result;
                            w_wdata_d     = w_fwd_b;
                            w_zero_d      = (w_alu_result == '0);
                        end
                    end
                end
            endcase
`else
            if (!stall_in) begin
                w_memread_d   = MemRead_EX;
                w_memwrite_d  = MemWrite_EX;
                w_resultsrc_d = ResultSrc_EX;
                w_regwrite_d  = RegWrite_EX;
                w_rd_d        = rd_EX;
                w_result_d    = w_alu_result;
                w_wdata_d     = w_fwd_b;
                w_zero_d      = (w_alu_result == '0);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_memread_q   <= 1'b0;
            r_memwrite_q  <= 1'b0;
            r_resultsrc_q <= 1'b0;
            r_regwrite_q  <= 1'b0;
            r_rd_q        <= '0;
            r_result_q    <= '0;
            r_wdata_q     <= '0;
            r_zero_q      <= 1'b0;
        end else begin
            r_memread_q   <= w_memread_d;
            r_memwrite_q  <= w_memwrite_d;
            r_resultsrc_q <= w_resultsrc_d;
            r_regwrite_q  <= w_regwrite_d;
            r_rd_q        <= w_rd_d;
            r_result_q    <= w_result_d;
            r_wdata_q     <= w_wdata_d;
            r_zero_q      <= w_zero_d;
        end
    end

`ifdef STAGE_EX_MUL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q       <= MUL_IDLE;
            r_cnt_q         <= '0;
            r_mcand_q       <= '0;
            r_mplier_q      <= '0;
            r_acc_q         <= '0;
            r_m_regwrite_q  <= 1'b0;
            r_m_memread_q   <= 1'b0;
            r_m_memwrite_q  <= 1'b0;
            r_m_resultsrc_q <= 1'b0;
            r_m_rd_q        <= '0;
            r_m_wdata_q     <= '0;
        end else begin
            r_state_q       <= w_state_d;
            r_cnt_q         <= w_cnt_d;
            r_mcand_q       <= w_mcand_d;
            r_mplier_q      <= w_mplier_d;
            r_acc_q         <= w_acc_d;
            r_m_regwrite_q  <= w_m_regwrite_d;
            r_m_memread_q   <= w_m_memread_d;
            r_m_memwrite_q  <= w_m_memwrite_d;
            r_m_resultsrc_q <= w_m_resultsrc_d;
            r_m_rd_q        <= w_m_rd_d;
            r_m_wdata_q     <= w_m_wdata_d;
        end
    end

    assign ex_busy = (r_state_q == MUL_RUN);
`else
    assign ex_busy = 1'b0;
`endif

    assign MemRead_MEM    = r_memread_q;
    assign MemWrite_MEM   = r_memwrite_q;
    assign ResultSrc_MEM  = r_resultsrc_q;
    assign RegWrite_MEM   = r_regwrite_q;
    assign rd_MEM         = r_rd_q;
    assign alu_result_MEM = r_result_q;
    assign write_data_MEM = r_wdata_q;
    assign zero_MEM       = r_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_stage_ex.sv
// ============================================================================
// Module : tb_stage_ex
// Brief  : Directed self-checking bench for stage_ex (MUL steps only when
//          STAGE_EX_MUL_EN is defined).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_stage_ex;
    import pipeline_pkg::*;

    logic       clk = 1'b0;
    logic       reset, stall_in, flush_in;
    logic       RegWrite_EX, MemRead_EX, MemWrite_EX, ResultSrc_EX;
    logic [3:0] alu_op_EX;
    logic       alu_src_EX;
    logic [7:0] rs1_data_EX, rs2_data_EX, imm_EX, fwd_mem_data, fwd_wb_data;
    logic [2:0] rd_EX;
    logic [1:0] forward_A, forward_B;
    logic       MemRead_MEM, MemWrite_MEM, ResultSrc_MEM, RegWrite_MEM;
    logic [2:0] rd_MEM;
    logic [7:0] alu_result_MEM, write_data_MEM;
    logic       zero_MEM, ex_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stage_ex #(.DATA_W(8), .REG_AW(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_in       (stall_in),
        .flush_in       (flush_in),
        .RegWrite_EX    (RegWrite_EX),
        .MemRead_EX     (MemRead_EX),
        .MemWrite_EX    (MemWrite_EX),
        .ResultSrc_EX   (ResultSrc_EX),
        .alu_op_EX      (alu_op_EX),
        .alu_src_EX     (alu_src_EX),
        .rs1_data_EX    (rs1_data_EX),
        .rs2_data_EX    (rs2_data_EX),
        .imm_EX         (imm_EX),
        .rd_EX          (rd_EX),
        .forward_A      (forward_A),
        .forward_B      (forward_B),
        .fwd_mem_data   (fwd_mem_data),
        .fwd_wb_data    (fwd_wb_data),
        .MemRead_MEM    (MemRead_MEM),
        .MemWrite_MEM   (MemWrite_MEM),
        .ResultSrc_MEM  (ResultSrc_MEM),
        .RegWrite_MEM   (RegWrite_MEM),
        .rd_MEM         (rd_MEM),
        .alu_result_MEM (alu_result_MEM),
        .write_data_MEM (write_data_MEM),
        .zero_MEM       (zero_MEM),
        .ex_busy        (ex_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] code, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] imm, input logic src);
        alu_op_EX   = code;
        rs1_data_EX = a;
        rs2_data_EX = b;
        imm_EX      = imm;
        alu_src_EX  = src;
    endtask

    initial begin
        reset = 1'b1; stall_in = 1'b0; flush_in = 1'b0;
        RegWrite_EX = 1'b1; MemRead_EX = 1'b1; MemWrite_EX = 1'b1; ResultSrc_EX = 1'b1;
        op(ALU_ADD, 8'h11, 8'h22, 8'h33, 1'b0);
        rd_EX = 3'd7; forward_A = FWD_REG; forward_B = FWD_REG;
        fwd_mem_data = 8'h00; fwd_wb_data = 8'h00;
        tick(); tick();
        check("reset_result", alu_result_MEM, 8'h00);
        check("reset_ctrl", {MemRead_MEM, MemWrite_MEM, ResultSrc_MEM, RegWrite_MEM}, 4'h0);
        check("reset_rd_wd_zero", {rd_MEM, write_data_MEM, zero_MEM}, 12'h000);
        check("reset_busy", ex_busy, 1'b0);

        reset = 1'b0;
        RegWrite_EX = 1'b1; MemRead_EX = 1'b0; MemWrite_EX = 1'b0; ResultSrc_EX = 1'b0;
        rd_EX = 3'd3;
        op(ALU_ADD, 8'h7F, 8'h00, 8'h01, 1'b1);
        tick();
        check("add_result", alu_result_MEM, 8'h80);
        check("add_zero", zero_MEM, 1'b0);
        check("add_ctrl", {RegWrite_MEM, rd_MEM}, {1'b1, 3'd3});

        op(ALU_SUB, 8'h09, 8'h05, 8'h00, 1'b0);
        forward_A = FWD_MEM; fwd_mem_data = 8'h05;
        tick();
        check("sub_fwd_mem", alu_result_MEM, 8'h00);
        check("sub_zero", zero_MEM, 1'b1);

        forward_A = 2'b11;
        op(ALU_SLT, 8'hFF, 8'h01, 8'h00, 1'b0);
        tick();
        check("slt_neg", alu_result_MEM, 8'h01);
        forward_A = FWD_REG;
        op(ALU_SLT, 8'h01, 8'hFF, 8'h00, 1'b0);
        tick();
        check("slt_pos", alu_result_MEM, 8'h00);

        op(ALU_SLL, 8'h81, 8'h00, 8'h03, 1'b1);
        tick();
        check("sll", alu_result_MEM, 8'h08);
        op(ALU_SRL, 8'h81, 8'hFB, 8'h00, 1'b0);
        tick();
        check("srl_low3", alu_result_MEM, 8'h10);
        op(ALU_XOR, 8'hF0, 8'h3C, 8'h00, 1'b0);
        tick();
        check("xor", alu_result_MEM, 8'hCC);
        op(ALU_AND, 8'hF0, 8'h3C, 8'h00, 1'b0);
        tick();
        check("and", alu_result_MEM, 8'h30);
        op(ALU_OR, 8'hF0, 8'h3C, 8'h00, 1'b0);
        tick();
        check("or", alu_result_MEM, 8'hFC);
        op(ALU_PASSB, 8'h12, 8'h34, 8'h56, 1'b1);
        tick();
        check("passb_imm", alu_result_MEM, 8'h56);
        op(4'hF, 8'h12, 8'h34, 8'h56, 1'b0);
        tick();
        check("undef_op", alu_result_MEM, 8'h00);
        check("undef_zero", zero_MEM, 1'b1);

        RegWrite_EX = 1'b0; MemWrite_EX = 1'b1;
        forward_B = FWD_WB; fwd_wb_data = 8'hA5;
        op(ALU_ADD, 8'h10, 8'h00, 8'h04, 1'b1);
        tick();
        check("store_wdata", write_data_MEM, 8'hA5);
        check("store_addr", alu_result_MEM, 8'h14);
        check("store_ctrl", {MemWrite_MEM, RegWrite_MEM}, 2'b10);

        forward_B = FWD_MEM; fwd_mem_data = 8'h3C;
        op(ALU_SUB, 8'h50, 8'h00, 8'h00, 1'b0);
        tick();
        check("fwdb_mem_sub", alu_result_MEM, 8'h14);

        RegWrite_EX = 1'b1; MemWrite_EX = 1'b0; MemRead_EX = 1'b1; ResultSrc_EX = 1'b1;
        forward_B = FWD_REG; rd_EX = 3'd6;
        op(ALU_ADD, 8'h20, 8'h00, 8'h02, 1'b1);
        tick();
        check("load_ctrl", {MemRead_MEM, ResultSrc_MEM, RegWrite_MEM, rd_MEM}, {3'b111, 3'd6});
        stall_in = 1'b1; flush_in = 1'b1;
        tick();
        check("flush_ctrl", {MemRead_MEM, MemWrite_MEM, ResultSrc_MEM, RegWrite_MEM}, 4'h0);
        check("flush_data", {rd_MEM, alu_result_MEM, write_data_MEM}, 19'h0);
        stall_in = 1'b0; flush_in = 1'b0;
        tick();
        check("post_flush_load", alu_result_MEM, 8'h22);
        stall_in = 1'b1; rd_EX = 3'd1; RegWrite_EX = 1'b0;
        op(ALU_ADD, 8'h01, 8'h00, 8'h01, 1'b1);
        tick(); tick();
        check("stall_hold_result", alu_result_MEM, 8'h22);
        check("stall_hold_ctrl", {RegWrite_MEM, rd_MEM}, {1'b1, 3'd6});
        stall_in = 1'b0;
        tick();
        check("stall_release", {RegWrite_MEM, rd_MEM, alu_result_MEM}, {1'b0, 3'd1, 8'h02});

        RegWrite_EX = 1'b1; MemRead_EX = 1'b0; ResultSrc_EX = 1'b0; rd_EX = 3'd5;
        op(ALU_MUL, 8'h0C, 8'h0B, 8'h00, 1'b0);
`ifdef STAGE_EX_MUL_EN
        tick();
        check("mul_start_bubble", RegWrite_MEM, 1'b0);
        op(ALU_ADD, 8'hEE, 8'hEE, 8'h00, 1'b0);
        rd_EX = 3'd2;
        for (int i = 0; i < 8; i++) begin
            check("mul_busy", ex_busy, 1'b1);
            check("mul_bubble", {RegWrite_MEM, alu_result_MEM}, 9'h0);
            tick();
        end
        check("mul_done_busy", ex_busy, 1'b0);
        tick();
        check("mul_result", alu_result_MEM, 8'h84);
        check("mul_ctrl", {RegWrite_MEM, rd_MEM}, {1'b1, 3'd5});
        RegWrite_EX = 1'b0;
        op(ALU_ADD, 8'h00, 8'h00, 8'h00, 1'b0);
        tick();

        RegWrite_EX = 1'b1; rd_EX = 3'd5;
        op(ALU_MUL, 8'h0C, 8'h0B, 8'h00, 1'b0);
        tick();
        RegWrite_EX = 1'b0; rd_EX = 3'd0;
        op(ALU_ADD, 8'h00, 8'h00, 8'h00, 1'b0);
        tick(); tick(); tick();
        check("mul_abort_busy_before", ex_busy, 1'b1);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        check("mul_abort_busy", ex_busy, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("mul_abort_no_result", {RegWrite_MEM, alu_result_MEM}, 9'h0);
            tick();
        end
        check("mul_abort_idle", ex_busy, 1'b0);
`else
        tick();
        check("mul_disabled_result", alu_result_MEM, 8'h00);
        check("mul_disabled_busy", ex_busy, 1'b0);
        check("mul_disabled_ctrl", {RegWrite_MEM, rd_MEM}, {1'b1, 3'd5});
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
